// File: rtl/oled_page_refresh.sv
// SSD1306-class page refresh engine: tracks a dirty bit per display page and
// streams only dirty pages from display RAM to the panel over 4-wire SPI
// (mode 0, MSB first), prefixing each page with page/column address commands.
module oled_page_refresh #(
   parameter int COLS     = 128,
   parameter int PAGES    = 8,
   parameter int ADDR_W   = 10,
   parameter int SCLK_DIV = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic              refresh_req,
   input  logic [PAGES-1:0]  dirty_set,
   output logic              rden,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [7:0]        ram_data,
   output logic              busy,
   output logic              frame_done,
   output logic              oled_dc,
   output logic              oled_sclk,
   output logic              oled_mosi
);

   localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam int CW = $clog2(COLS);
   localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   // TX is the shared byte serialiser; ret_q holds where to go once the byte is out.
   typedef enum logic [3:0] {
      S_IDLE, S_SCAN, S_CMD0, S_CMD1, S_CMD2, S_FETCH, S_DATA, S_TX, S_NEXT
   } state_t;

   state_t             state_q, ret_q;
   logic [PAGES-1:0]   dirty_q, dirty_d, clr_vec;
   logic [PW-1:0]      ptr_q, page_q, hit_page, ptr_nxt;
   logic               found, set_page, pend_q;
   logic [CW-1:0]      col_q;
   logic [7:0]         shreg_q;
   logic [DW-1:0]      ph_q;
   logic [3:0]         half_q;
   logic               rden_q, busy_q, frame_done_q, dc_q, sclk_q, mosi_q;
   logic [ADDR_W-1:0]  addr_q;

   assign rden       = rden_q;
   assign rdaddress  = addr_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign oled_dc    = dc_q;
   assign oled_sclk  = sclk_q;
   assign oled_mosi  = mosi_q;

   // A page marked dirty while it is being sent (pend_q) keeps its dirty bit at NEXT,
   // so the fresh content is sent again on a later pass.
   assign set_page = dirty_set[page_q] | refresh_req;
   assign ptr_nxt  = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;

   // Dirty mask next state: a set on the clearing cycle wins.
   always_comb begin
      clr_vec = '0;
      if (state_q == S_NEXT && !pend_q) clr_vec[page_q] = 1'b1;
      dirty_d = (dirty_q & ~clr_vec) | dirty_set | {PAGES{refresh_req}};
   end

   // Round-robin search for the first dirty page at or after ptr_q.
   always_comb begin
      int idx;
      found    = 1'b0;
      hit_page = '0;
      for (int k = 0; k < PAGES; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= PAGES) idx = idx - PAGES;
         if (!found && dirty_q[idx]) begin
            found    = 1'b1;
            hit_page = PW'(idx);
         end
      end
   end

   // Sequencer, byte serialiser and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ret_q        <= S_IDLE;
         dirty_q      <= '1;
         ptr_q        <= '0;
         page_q       <= '0;
         col_q        <= '0;
         shreg_q      <= '0;
         ph_q         <= '0;
         half_q       <= '0;
         pend_q       <= 1'b0;
         rden_q       <= 1'b0;
         addr_q       <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         dc_q         <= 1'b0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
      end else begin
         dirty_q      <= dirty_d;
         frame_done_q <= (dirty_q != '0) && (dirty_d == '0);
         pend_q       <= (state_q == S_SCAN) ? 1'b0 : (pend_q | set_page);
         rden_q       <= 1'b0;
         case (state_q)
            S_IDLE: if (init_done && dirty_q != '0) state_q <= S_SCAN;
            S_SCAN: begin
               if (!init_done) begin
                  state_q <= S_IDLE;
               end else if (found) begin
                  page_q  <= hit_page;
                  col_q   <= '0;
                  busy_q  <= 1'b1;
                  dc_q    <= 1'b0;
                  state_q <= S_CMD0;
               end else begin
                  ptr_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
            S_CMD0, S_CMD1, S_CMD2, S_DATA: begin
               // Load the byte and start its first low phase with MSB on mosi.
               logic [7:0] b;
               b = 8'h00;
               case (state_q)
                  S_CMD0: begin
                     b     = 8'hB0 | 8'(page_q);
                     ret_q <= S_CMD1;
                  end
                  S_CMD1: begin
                     b     = 8'h00;
                     ret_q <= S_CMD2;
                  end
                  S_CMD2: begin
                     b     = 8'h10;
                     ret_q <= S_FETCH;
                  end
                  default: begin
                     b = ram_data;
                     if (col_q == CW'(COLS - 1)) begin
                        ret_q <= S_NEXT;
                     end else begin
                        ret_q <= S_FETCH;
                        col_q <= col_q + 1'b1;
                     end
                  end
               endcase
               shreg_q <= b;
               mosi_q  <= b[7];
               sclk_q  <= 1'b0;
               ph_q    <= '0;
               half_q  <= '0;
               state_q <= S_TX;
            end
            S_FETCH: state_q <= S_DATA;
            S_TX: begin
               if (ph_q == DW'(SCLK_DIV - 1)) begin
                  ph_q <= '0;
                  if (half_q == 4'd15) begin
                     sclk_q <= 1'b0;
                     mosi_q <= 1'b0;
                     half_q <= '0;
                     if (!init_done) begin
                        busy_q  <= 1'b0;
                        dc_q    <= 1'b0;
                        state_q <= S_IDLE;
                     end else begin
                        case (ret_q)
                           S_CMD1, S_CMD2: begin
                              dc_q    <= 1'b0;
                              state_q <= ret_q;
                           end
                           S_FETCH: begin
                              dc_q    <= 1'b1;
                              rden_q  <= 1'b1;
                              addr_q  <= ADDR_W'(int'(page_q) * COLS + int'(col_q));
                              state_q <= S_FETCH;
                           end
                           default: state_q <= S_NEXT;
                        endcase
                     end
                  end else begin
                     half_q <= half_q + 1'b1;
                     if (!half_q[0]) begin
                        sclk_q <= 1'b1;
                     end else begin
                        sclk_q  <= 1'b0;
                        mosi_q  <= shreg_q[6];
                        shreg_q <= {shreg_q[6:0], 1'b0};
                     end
                  end
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            S_NEXT: begin
               ptr_q   <= ptr_nxt;
               busy_q  <= 1'b0;
               state_q <= S_SCAN;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_page_refresh.sv
// Bench for oled_page_refresh: expected SPI bytes are queued by the stimulus,
// an independent monitor decodes the SPI lines and compares against the queue.
module tb_oled_page_refresh;

   localparam int COLS = 4, PAGES = 2, ADDR_W = 10, SD = 2;

   logic clk = 1'b0;
   logic rst = 1'b1, init_done = 1'b0, refresh_req = 1'b0;
   logic [PAGES-1:0] dirty_set = '0;
   logic rden, busy, frame_done, oled_dc, oled_sclk, oled_mosi;
   logic [ADDR_W-1:0] rdaddress;
   logic [7:0] ram_data = 8'h00;
   logic [7:0] mem [COLS*PAGES];

   logic [8:0] exp_q [$];
   int checks = 0, failures = 0, fd_cnt = 0;

   oled_page_refresh #(.COLS(COLS), .PAGES(PAGES), .ADDR_W(ADDR_W), .SCLK_DIV(SD)) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .refresh_req(refresh_req),
      .dirty_set(dirty_set), .rden(rden), .rdaddress(rdaddress), .ram_data(ram_data),
      .busy(busy), .frame_done(frame_done), .oled_dc(oled_dc), .oled_sclk(oled_sclk),
      .oled_mosi(oled_mosi));

   always #5 clk = ~clk;

   // display RAM model: data valid the cycle after rden
   always @(posedge clk) if (rden) ram_data <= mem[int'(rdaddress) % (COLS*PAGES)];

   always @(negedge clk) if (!rst && frame_done) fd_cnt++;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // reference: a page transfer is three address commands then COLS data bytes
   task automatic push_page(int p, int ncols);
      exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h10});
      for (int c = 0; c < ncols; c++) exp_q.push_back({1'b1, mem[p*COLS + c]});
   endtask

   // SPI monitor
   int nbits = 0, run = 0;
   logic prev_sclk = 1'b0, byte_dc = 1'b0, dc_bad = 1'b0, mosi_bad = 1'b0, rise_mosi = 1'b0;
   logic [7:0] shv = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         nbits = 0; run = 0; prev_sclk = 1'b0;
      end else begin
         if (oled_sclk && !prev_sclk) begin
            if (nbits > 0) check("sclk_low_len", run, SD);
            if (nbits == 0) begin
               byte_dc = oled_dc; dc_bad = 1'b0;
            end else if (oled_dc != byte_dc) dc_bad = 1'b1;
            rise_mosi = oled_mosi; mosi_bad = 1'b0;
            shv = {shv[6:0], oled_mosi};
            nbits++; run = 1;
            if (nbits == 8) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_byte", {23'd0, byte_dc, shv}, 9'h1FF);
               end else begin
                  logic [8:0] e;
                  e = exp_q.pop_front();
                  check("spi_byte", {22'd0, dc_bad, byte_dc, shv}, {23'd0, e});
               end
            end
         end else if (!oled_sclk && prev_sclk) begin
            check("sclk_high_len", run, SD);
            check("mosi_stable", int'(mosi_bad), 0);
            run = 1;
            if (nbits == 8) nbits = 0;
         end else begin
            run++;
            if (oled_sclk && oled_mosi != rise_mosi) mosi_bad = 1'b1;
         end
         prev_sclk = oled_sclk;
      end
   end

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(logic [PAGES-1:0] m, logic rr);
      @(posedge clk); #1;
      dirty_set = m; refresh_req = rr;
      @(posedge clk); #1;
      dirty_set = '0; refresh_req = 1'b0;
   endtask

   task automatic drain(string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(negedge clk); n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic wait_rd(int a);
      int n = 0;
      while (!(rden && int'(rdaddress) == a) && n < 2000) begin
         @(negedge clk); n++;
      end
      check("rden_seen", int'(rden && int'(rdaddress) == a), 1);
   endtask

   initial begin
      int fd0;
      for (int i = 0; i < COLS*PAGES; i++) mem[i] = 8'hA0 + 8'(i);
      // reset state
      cycles(3);
      @(negedge clk);
      check("reset_outputs", {rden, rdaddress, busy, frame_done, oled_dc, oled_sclk, oled_mosi}, 0);
      push_page(0, COLS); push_page(1, COLS);
      @(posedge clk); #1 rst = 1'b0;
      cycles(6);
      @(negedge clk);
      check("idle_without_init", exp_q.size() + int'(busy), 2*(3+COLS));

      // full frame after init
      fd0 = fd_cnt;
      init_done = 1'b1;
      drain("frame1_drain");
      cycles(12);
      @(negedge clk);
      check("frame1_done_pulses", fd_cnt - fd0, 1);
      check("frame1_busy_low", int'(busy), 0);

      // single page
      fd0 = fd_cnt;
      push_page(1, COLS);
      pulse(2'b10, 1'b0);
      drain("page1_drain");
      cycles(12);
      @(negedge clk);
      check("page1_done_pulse", fd_cnt - fd0, 1);
      check("page1_busy_low", int'(busy), 0);

      // re-dirty page 0 while it streams: round robin sends page 1, then page 0 again
      push_page(0, COLS); push_page(1, COLS); push_page(0, COLS);
      pulse(2'b00, 1'b1);
      wait_rd(1);
      pulse(2'b01, 1'b0);
      drain("rr_drain");
      cycles(12);

      // init_done drop during A5: byte completes, page abandoned, then resent
      push_page(0, COLS); push_page(1, 2);
      pulse(2'b00, 1'b1);
      wait_rd(5);
      cycles(6);
      init_done = 1'b0;
      drain("abort_drain");
      cycles(60);
      @(negedge clk);
      check("abort_busy_low", int'(busy), 0);
      check("abort_no_bytes", exp_q.size(), 0);
      push_page(1, COLS);
      @(posedge clk); #1 init_done = 1'b1;
      drain("resume_drain");
      cycles(12);

      // reset mid-byte
      push_page(0, COLS); push_page(1, COLS);
      pulse(2'b00, 1'b1);
      wait_rd(2);
      cycles(8);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("rst_midbyte_outputs", {oled_sclk, oled_mosi, oled_dc, busy}, 0);
      push_page(0, COLS); push_page(1, COLS);
      @(posedge clk); #1 rst = 1'b0;
      drain("post_rst_drain");
      cycles(12);

      // randomized RAM contents and page masks, issued while idle
      for (int it = 0; it < 6; it++) begin
         logic [PAGES-1:0] m;
         logic rr;
         for (int i = 0; i < COLS*PAGES; i++) mem[i] = 8'($urandom);
         m  = PAGES'($urandom_range(1, 3));
         rr = (m == 2'b11) && ($urandom_range(0, 1) == 1);
         for (int p = 0; p < PAGES; p++) if (m[p]) push_page(p, COLS);
         if (rr) pulse(2'b00, 1'b1);
         else    pulse(m, 1'b0);
         drain("rand_drain");
         cycles(12);
         @(negedge clk);
         check("rand_busy_low", int'(busy), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
